// File: rtl/fir_pkg.sv
// Shared constants, register map and response encodings for the FIR coefficient slave.
package fir_pkg;

    localparam int unsigned NTAPS     = 25;
    localparam int unsigned COEF_W    = 16;
    localparam int unsigned SHIFT_W   = 4;

    localparam int unsigned COEF_BASE = 32'h00;
    localparam int unsigned SHIFT_OFF = 32'h64;
    localparam int unsigned CTRL_OFF  = 32'h68;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned ID_TAP    = 12;
    localparam int unsigned ID_COEF   = 256;
    localparam int unsigned ID_SHIFT  = 8;

    typedef enum logic [1:0] {
        REG_COEF,
        REG_SHIFT,
        REG_CTRL,
        REG_BAD
    } reg_kind_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    // Classify a word index (byte address / 4) against the register map.
    function automatic reg_kind_e reg_kind(input int unsigned widx, input int unsigned ntaps);
        reg_kind_e k;
        k = REG_BAD;
        if (widx < COEF_BASE / 4 + ntaps) begin
            k = REG_COEF;
        end else if (widx == SHIFT_OFF / 4) begin
            k = REG_SHIFT;
        end else if (widx == CTRL_OFF / 4) begin
            k = REG_CTRL;
        end
        return k;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient and shift storage with byte-enabled writes,
// combinational shadow readback and an atomic shadow-to-active copy.
module fir_coef_bank #(
    parameter int unsigned NTAPS  = fir_pkg::NTAPS,
    parameter int unsigned COEF_W = fir_pkg::COEF_W,
    parameter int unsigned IDX_W  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [31:0]                  wr_data,
    input  logic [3:0]                   wr_strb,
    input  logic                         commit,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic [31:0]                  rd_data_c,
    output logic                         rd_ok_c,
    output logic [NTAPS*COEF_W-1:0]      coef_o,
    output logic [fir_pkg::SHIFT_W-1:0]  shift_o
);
    import fir_pkg::*;

    localparam int unsigned TAP_W = $clog2(NTAPS);

    logic [COEF_W-1:0]  shadow_coef [NTAPS];
    logic [COEF_W-1:0]  active_coef [NTAPS];
    logic [SHIFT_W-1:0] shadow_shift;
    logic [31:0]        byte_mask_c;
    logic [TAP_W-1:0]   wr_tap_c;
    reg_kind_e          wr_kind_c;
    reg_kind_e          rd_kind_c;
    logic               high_bits_unused;

    assign byte_mask_c      = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign wr_tap_c         = wr_idx[TAP_W-1:0];
    assign wr_kind_c        = reg_kind(32'(wr_idx), NTAPS);
    assign rd_kind_c        = reg_kind(32'(rd_idx), NTAPS);
    assign high_bits_unused = ^{wr_data[31:COEF_W], byte_mask_c[31:COEF_W]};

    // Shadow readback: coefficients sign-extend, CTRL reads as zero.
    always_comb begin
        rd_data_c = '0;
        rd_ok_c   = 1'b1;
        case (rd_kind_c)
            REG_COEF:  rd_data_c = 32'($signed(shadow_coef[rd_idx[TAP_W-1:0]]));
            REG_SHIFT: rd_data_c = 32'(shadow_shift);
            REG_CTRL:  rd_data_c = '0;
            default:   rd_ok_c   = 1'b0;
        endcase
    end

    // A shadow write on the commit edge is not part of that copy (nonblocking read of old shadow).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                shadow_coef[TAP_W'(i)] <= (i == ID_TAP) ? COEF_W'(ID_COEF) : '0;
                active_coef[TAP_W'(i)] <= (i == ID_TAP) ? COEF_W'(ID_COEF) : '0;
            end
            shadow_shift <= SHIFT_W'(ID_SHIFT);
            shift_o      <= SHIFT_W'(ID_SHIFT);
        end else begin
            if (wr_en && wr_kind_c == REG_COEF) begin
                shadow_coef[wr_tap_c] <= (shadow_coef[wr_tap_c] & ~byte_mask_c[COEF_W-1:0])
                                       | (wr_data[COEF_W-1:0] & byte_mask_c[COEF_W-1:0]);
            end
            if (wr_en && wr_kind_c == REG_SHIFT && wr_strb[0]) begin
                shadow_shift <= wr_data[SHIFT_W-1:0];
            end
            if (commit) begin
                for (int unsigned i = 0; i < NTAPS; i++) begin
                    active_coef[TAP_W'(i)] <= shadow_coef[TAP_W'(i)];
                end
                shift_o <= shadow_shift;
            end
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_coef
        assign coef_o[g*COEF_W +: COEF_W] = active_coef[g];
    end

endmodule

// File: rtl/fir_coef_axil_slave.sv
// AXI4-Lite responder for the 2D FIR kernel: AW/W holding registers, B and R
// response registers, and the commit sequencing into the coefficient bank.
module fir_coef_axil_slave #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NTAPS  = fir_pkg::NTAPS,
    parameter int unsigned COEF_W = fir_pkg::COEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_W-1:0]       s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [NTAPS*COEF_W-1:0] coef_o,
    output logic [3:0]              shift_o,
    output logic                    coef_update_o
);
    import fir_pkg::*;

    localparam int unsigned IDX_W = ADDR_W - 2;

    logic              live;
    logic              aw_held;
    logic              w_held;
    logic [IDX_W-1:0]  aw_idx;
    wbeat_t            w_beat;
    logic              commit_pending;
    logic              exec_c;
    logic              commit_req_c;
    reg_kind_e         wr_kind_c;
    logic [31:0]       rd_data_c;
    logic              rd_ok_c;
    logic              addr_lsb_unused;

    // Readies stay low until the first edge after reset releases.
    assign s_awready       = live & ~aw_held & ~s_bvalid;
    assign s_wready        = live & ~w_held & ~s_bvalid;
    assign s_arready       = live & ~s_rvalid;
    assign exec_c          = aw_held & w_held;
    assign wr_kind_c       = reg_kind(32'(aw_idx), NTAPS);
    assign commit_req_c    = exec_c & (wr_kind_c == REG_CTRL) & w_beat.strb[0] & w_beat.data[0];
    assign addr_lsb_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            live           <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_idx         <= '0;
            w_beat         <= '0;
            s_bvalid       <= 1'b0;
            s_bresp        <= RESP_OKAY;
            s_rvalid       <= 1'b0;
            s_rdata        <= '0;
            s_rresp        <= RESP_OKAY;
            commit_pending <= 1'b0;
            coef_update_o  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_idx  <= s_awaddr[ADDR_W-1:2];
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_beat <= '{data: s_wdata, strb: s_wstrb};
            end
            // Write executes once both halves are held; bvalid blocks new captures.
            if (exec_c) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= (wr_kind_c == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
            commit_pending <= commit_req_c;
            coef_update_o  <= commit_pending;
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_data_c;
                s_rresp  <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    fir_coef_bank #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (exec_c),
        .wr_idx    (aw_idx),
        .wr_data   (w_beat.data),
        .wr_strb   (w_beat.strb),
        .commit    (commit_pending),
        .rd_idx    (s_araddr[ADDR_W-1:2]),
        .rd_data_c (rd_data_c),
        .rd_ok_c   (rd_ok_c),
        .coef_o    (coef_o),
        .shift_o   (shift_o)
    );

endmodule

// File: tb/tb_fir_coef_axil_slave.sv
// Scoreboard bench for fir_coef_axil_slave: drivers queue expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_fir_coef_axil_slave;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   s_awaddr = '0;
    logic         s_awvalid = 1'b0;
    logic         s_awready;
    logic [31:0]  s_wdata = '0;
    logic [3:0]   s_wstrb = '0;
    logic         s_wvalid = 1'b0;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready = 1'b1;
    logic [7:0]   s_araddr = '0;
    logic         s_arvalid = 1'b0;
    logic         s_arready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rvalid;
    logic         s_rready = 1'b1;
    logic [399:0] coef_o;
    logic [3:0]   shift_o;
    logic         coef_update_o;

    logic [1:0]   b_q [$];
    rexp_t        r_q [$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           upd_count = 0;
    int           last_upd = 0;
    int           last_bv_rise = 0;
    logic         bvalid_prev = 1'b0;
    logic [15:0]  exp_tap [25];
    logic [3:0]   exp_shift;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_coef_axil_slave #(.ADDR_W(8), .NTAPS(25), .COEF_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .coef_o(coef_o), .shift_o(shift_o), .coef_update_o(coef_update_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Response monitor plus commit-pulse bookkeeping.
    always @(negedge clk) begin
        rexp_t e;
        if (!rst) begin
            if (s_bvalid && !bvalid_prev) last_bv_rise = cyc;
            if (coef_update_o) begin
                upd_count++;
                last_upd = cyc;
            end
            if (s_bvalid && s_bready) begin
                if (b_q.size() == 0) fail("b_unexpected");
                else check("bresp", 32'(s_bresp), 32'(b_q.pop_front()));
            end
            if (s_rvalid && s_rready) begin
                if (r_q.size() == 0) fail("r_unexpected");
                else begin
                    e = r_q.pop_front();
                    check("rresp", 32'(s_rresp), 32'(e.resp));
                    check("rdata", s_rdata, e.data);
                end
            end
        end
        bvalid_prev = s_bvalid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) begin
            fail("response_timeout");
            b_q.delete();
            r_q.delete();
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                             input logic [1:0] exp_resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        b_q.push_back(exp_resp);
        s_awaddr = a; s_awvalid = 1'b1;
        s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick();
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_wvalid = 1'b0;  w_done = 1;  end
            n++;
        end
        if (!(aw_done && w_done)) begin
            fail("write_handshake_timeout");
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
        drain();
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [1:0] exp_resp, input logic [31:0] exp_data);
        bit hs, done;
        int n;
        r_q.push_back('{resp: exp_resp, data: exp_data});
        s_araddr = a; s_arvalid = 1'b1;
        done = 0; n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            hs = s_arvalid && s_arready;
            tick();
            if (hs) begin s_arvalid = 1'b0; done = 1; end
            n++;
        end
        if (!done) begin
            fail("read_handshake_timeout");
            s_arvalid = 1'b0;
        end
        drain();
    endtask

    task automatic check_active(input string tag);
        for (int i = 0; i < 25; i++) begin
            check($sformatf("%s_tap%0d", tag, i), 32'(coef_o[i*16 +: 16]), 32'(exp_tap[i]));
        end
        check($sformatf("%s_shift", tag), 32'(shift_o), 32'(exp_shift));
    endtask

    task automatic set_identity();
        for (int i = 0; i < 25; i++) exp_tap[i] = 16'h0000;
        exp_tap[12] = 16'h0100;
        exp_shift = 4'd8;
    endtask

    initial begin
        int base;
        set_identity();

        // Reset values while rst is held.
        repeat (3) tick();
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_update", 32'(coef_update_o), 32'd0);
        check_active("rst");
        rst = 1'b0;
        tick();

        // Identity readback.
        axi_read(8'h30, OK, 32'h0000_0100);
        axi_read(8'h64, OK, 32'h0000_0008);

        // W three cycles ahead of AW, then latency from AW acceptance.
        b_q.push_back(OK);
        s_wdata = 32'hFFFF_FFF0; s_wstrb = 4'b0011; s_wvalid = 1'b1;
        @(negedge clk);
        check("wlead_wready", 32'(s_wready), 32'd1);
        tick();
        s_wvalid = 1'b0;
        tick(); tick();
        s_awaddr = 8'h04; s_awvalid = 1'b1;
        @(negedge clk);
        check("wlead_awready", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0;
        check("wlead_bvalid_early", 32'(s_bvalid), 32'd0);
        tick();
        check("wlead_bvalid_latency", 32'(s_bvalid), 32'd1);
        drain();
        axi_read(8'h04, OK, 32'hFFFF_FFF0);
        check_active("shadow_only");

        // Commit: active tap1 = -16, one update pulse one cycle after bvalid rises.
        base = upd_count;
        axi_write(8'h68, 32'h0000_0001, 4'b0001, OK);
        repeat (3) tick();
        exp_tap[1] = 16'hFFF0;
        check_active("commit1");
        check("commit1_pulses", 32'(upd_count - base), 32'd1);
        check("commit1_latency", 32'(last_upd - last_bv_rise), 32'd1);

        // Bad addresses, CTRL reads and byte enables.
        axi_write(8'h80, 32'h0000_1234, 4'b1111, ERR);
        axi_read(8'h7C, ERR, 32'h0);
        axi_read(8'h68, OK, 32'h0);
        base = upd_count;
        axi_write(8'h00, 32'h1234_5678, 4'b0010, OK);
        axi_read(8'h00, OK, 32'h0000_5600);
        axi_write(8'h00, 32'hAABB_CCDD, 4'b1101, OK);
        axi_read(8'h00, OK, 32'h0000_56DD);
        axi_write(8'h64, 32'hFFFF_FFF3, 4'b1110, OK);
        axi_read(8'h64, OK, 32'h0000_0008);
        axi_write(8'h64, 32'hFFFF_FFF3, 4'b0001, OK);
        axi_read(8'h64, OK, 32'h0000_0003);
        axi_write(8'h0B, 32'h0000_8001, 4'b0011, OK);
        axi_read(8'h08, OK, 32'hFFFF_8001);
        axi_write(8'h68, 32'h0000_0001, 4'b0000, OK);
        axi_write(8'h68, 32'h0000_0002, 4'b0001, OK);
        repeat (3) tick();
        check("nocommit_pulses", 32'(upd_count - base), 32'd0);
        check_active("nocommit");
        axi_write(8'h68, 32'hFFFF_FFFF, 4'b0001, OK);
        repeat (3) tick();
        exp_tap[0] = 16'h56DD; exp_tap[2] = 16'h8001; exp_shift = 4'd3;
        check_active("commit2");
        check("commit2_pulses", 32'(upd_count - base), 32'd1);

        // Back-pressure, with a read landing on the same edge as a write to that address.
        s_bready = 1'b0; s_rready = 1'b0;
        b_q.push_back(OK);
        r_q.push_back('{resp: OK, data: 32'hFFFF_FFF0});
        s_awaddr = 8'h04; s_awvalid = 1'b1;
        s_wdata = 32'h0000_1234; s_wstrb = 4'b1111; s_wvalid = 1'b1;
        @(negedge clk);
        check("stall_aw_accept", 32'({s_awready, s_wready}), 32'd3);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 8'h04; s_arvalid = 1'b1;
        @(negedge clk);
        check("stall_ar_accept", 32'(s_arready), 32'd1);
        tick();
        s_arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_bvalid", 32'(s_bvalid), 32'd1);
            check("stall_rvalid", 32'(s_rvalid), 32'd1);
            check("stall_rdata", s_rdata, 32'hFFFF_FFF0);
            check("stall_bresp", 32'(s_bresp), 32'(OK));
            check("stall_awready", 32'(s_awready), 32'd0);
            check("stall_wready", 32'(s_wready), 32'd0);
        end
        tick();
        s_bready = 1'b1; s_rready = 1'b1;
        drain();
        axi_read(8'h04, OK, 32'h0000_1234);
        axi_write(8'h0C, 32'h0000_0009, 4'b1111, OK);
        axi_read(8'h0C, OK, 32'h0000_0009);

        // Reset with AW held and W pending.
        s_awaddr = 8'h14; s_awvalid = 1'b1;
        @(negedge clk);
        check("rstmid_aw_accept", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0;
        rst = 1'b1;
        s_wdata = 32'h0000_0077; s_wstrb = 4'b1111; s_wvalid = 1'b1;
        tick();
        check("rstmid_bvalid", 32'(s_bvalid), 32'd0);
        check("rstmid_rvalid", 32'(s_rvalid), 32'd0);
        check("rstmid_rdata", s_rdata, 32'h0);
        check("rstmid_awready", 32'(s_awready), 32'd0);
        check("rstmid_wready", 32'(s_wready), 32'd0);
        check("rstmid_update", 32'(coef_update_o), 32'd0);
        set_identity();
        check_active("rstmid");
        s_wvalid = 1'b0;
        rst = 1'b0;
        tick(); tick();
        axi_read(8'h14, OK, 32'h0);
        axi_read(8'h04, OK, 32'h0);
        axi_read(8'h64, OK, 32'h0000_0008);
        check("end_update", 32'(coef_update_o), 32'd0);
        check("end_bq_empty", 32'(b_q.size()), 32'd0);
        check("end_rq_empty", 32'(r_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
